// File: rtl/and_gate_pkg.sv
// Shared helpers for the and_gate slice: sizing of the popcount result.
package and_gate_pkg;

    // Bits needed to hold a count from 0 to width inclusive (never less than 1).
    function automatic int clog2_cnt(input int width);
        int n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << n) < (width + 1)) begin
                n = n + 1;
            end
        end
        return (n < 1) ? 1 : n;
    endfunction

endpackage

// File: rtl/and_popcount.sv
// Combinational population count of a WIDTH-bit vector.
module and_popcount
    import and_gate_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int CNT_W = clog2_cnt(WIDTH)
) (
    input  logic [WIDTH-1:0] vec_i,
    output logic [CNT_W-1:0] cnt_o
);

    always_comb begin
        cnt_o = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_o = cnt_o + CNT_W'(vec_i[i]);
        end
    end

endmodule

// File: rtl/and_gate.sv
// Bitwise 2-input AND with a combinational result and a registered copy
// carrying valid plus all-ones / any-one / popcount summary flags.
module and_gate
    import and_gate_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0]              a,
    input  logic [WIDTH-1:0]              b,
    output logic [WIDTH-1:0]              y,
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic [WIDTH-1:0]              y_q,
    output logic                          out_valid,
    output logic                          all_q,
    output logic                          any_q,
    output logic [clog2_cnt(WIDTH)-1:0]   cnt_q
);

    localparam int CNT_W = clog2_cnt(WIDTH);

    logic [CNT_W-1:0] cnt_w;
    logic [WIDTH-1:0] y_d;
    logic             all_d;
    logic             any_d;
    logic [CNT_W-1:0] cnt_d;

    assign y = a & b;

    and_popcount #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_popcount (
        .vec_i (y),
        .cnt_o (cnt_w)
    );

    // Data registers only load on a qualified input; otherwise they hold.
    always_comb begin
        y_d   = y_q;
        all_d = all_q;
        any_d = any_q;
        cnt_d = cnt_q;
        if (in_valid) begin
            y_d   = y;
            all_d = &y;
            any_d = |y;
            cnt_d = cnt_w;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q       <= '0;
            all_q     <= 1'b0;
            any_q     <= 1'b0;
            cnt_q     <= '0;
            out_valid <= 1'b0;
        end else begin
            y_q       <= y_d;
            all_q     <= all_d;
            any_q     <= any_d;
            cnt_q     <= cnt_d;
            out_valid <= in_valid;
        end
    end

endmodule

// File: tb/tb_and_gate.sv
// Directed bench for and_gate: WIDTH=1 combinational checks and a WIDTH=8
// registered path checked against a scoreboard of expected results.
module tb_and_gate;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // WIDTH=1 instance, never clocked
    logic a1, b1, y1, clk1, rst1, iv1, yq1, ov1, all1, any1;
    logic [0:0] cnt1;

    // WIDTH=8 instance
    logic [7:0] a8, b8, y8, yq8;
    logic       rst, iv, ov8, all8, any8;
    logic [3:0] cnt8;

    and_gate #(.WIDTH(1)) u_dut1 (
        .a(a1), .b(b1), .y(y1), .clk(clk1), .rst(rst1), .in_valid(iv1),
        .y_q(yq1), .out_valid(ov1), .all_q(all1), .any_q(any1), .cnt_q(cnt1)
    );

    and_gate #(.WIDTH(8)) u_dut8 (
        .a(a8), .b(b8), .y(y8), .clk(clk), .rst(rst), .in_valid(iv),
        .y_q(yq8), .out_valid(ov8), .all_q(all8), .any_q(any8), .cnt_q(cnt8)
    );

    typedef struct packed {
        logic [7:0] y;
        logic       all;
        logic       any;
        logic [3:0] cnt;
    } exp_t;

    exp_t sb[$];
    exp_t last;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input logic [7:0] av, input logic [7:0] bv, input logic v, input logic r);
        exp_t e;
        a8  = av;
        b8  = bv;
        iv  = v;
        rst = r;
        #1;
        chk("y_comb", 32'(y8), 32'(av & bv));
        if (v && !r) begin
            e.y   = av & bv;
            e.all = &e.y;
            e.any = |e.y;
            e.cnt = 4'($countones(e.y));
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        chk("y_after_edge", 32'(y8), 32'(av & bv));
        if (r) begin
            sb.delete();
            last = '0;
            chk("rst_out_valid", 32'(ov8), 32'd0);
            chk("rst_y_q", 32'(yq8), 32'd0);
            chk("rst_all_q", 32'(all8), 32'd0);
            chk("rst_any_q", 32'(any8), 32'd0);
            chk("rst_cnt_q", 32'(cnt8), 32'd0);
        end else if (sb.size() > 0) begin
            last = sb.pop_front();
            chk("out_valid", 32'(ov8), 32'd1);
            chk("y_q", 32'(yq8), 32'(last.y));
            chk("all_q", 32'(all8), 32'(last.all));
            chk("any_q", 32'(any8), 32'(last.any));
            chk("cnt_q", 32'(cnt8), 32'(last.cnt));
        end else begin
            chk("idle_out_valid", 32'(ov8), 32'd0);
            chk("hold_y_q", 32'(yq8), 32'(last.y));
            chk("hold_all_q", 32'(all8), 32'(last.all));
            chk("hold_any_q", 32'(any8), 32'(last.any));
            chk("hold_cnt_q", 32'(cnt8), 32'(last.cnt));
        end
    endtask

    initial begin
        logic xv;
        logic [1:0] ab;
        xv   = 1'bx;
        last = '0;
        clk1 = 1'b0;
        rst1 = 1'b0;
        iv1  = 1'b0;
        a8   = '0;
        b8   = '0;
        iv   = 1'b0;
        rst  = 1'b1;

        // WIDTH=1 purely combinational behaviour
        a1 = 1'b1;
        b1 = 1'b0;
        #1;
        chk("w1_a1_b0", 32'(y1), 32'd0);
        for (int i = 0; i < 4; i++) begin
            ab = 2'(i);
            a1 = ab[1];
            b1 = ab[0];
            #1;
            chk("w1_sweep", 32'(y1), (i == 3) ? 32'd1 : 32'd0);
        end
        a1 = xv;
        b1 = 1'b0;
        #1;
        chk("w1_x_and_0", 32'(y1), 32'd0);
        b1 = 1'b1;
        #1;
        chk("w1_x_and_1", 32'(y1), 32'(1'b1 & xv));

        // Reset held two clocks with valid all-ones inputs
        cycle(8'hFF, 8'hFF, 1'b1, 1'b1);
        cycle(8'hFF, 8'hFF, 1'b1, 1'b1);

        cycle(8'hF0, 8'h3C, 1'b1, 1'b0);
        cycle(8'hFF, 8'hFF, 1'b1, 1'b0);
        cycle(8'h00, 8'hFF, 1'b1, 1'b0);

        // Back-to-back distinct operands
        cycle(8'hA5, 8'h0F, 1'b1, 1'b0);
        cycle(8'h5A, 8'hFF, 1'b1, 1'b0);
        cycle(8'h81, 8'hC3, 1'b1, 1'b0);

        // Valid drops: data regs hold
        cycle(8'h12, 8'h34, 1'b0, 1'b0);
        cycle(8'hFF, 8'hFF, 1'b0, 1'b0);

        // Mid-stream reset drops the in-flight result
        cycle(8'h7E, 8'h7E, 1'b1, 1'b0);
        cycle(8'hFF, 8'hFF, 1'b1, 1'b1);
        cycle(8'h00, 8'h00, 1'b0, 1'b0);
        cycle(8'hC0, 8'h80, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
